// File: rtl/sram_pkg.sv
// Shared types and constants for the simple-dual-port SRAM with hardware clear.
// Optional macro SRAM_RD_BYPASS_EN (used in sram_sdp_clr) selects write-first collision reads.
package sram_pkg;

   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

   // Widest word the zero constant covers; users slice it to DATA_WIDTH.
   localparam int unsigned MAX_DATA_WIDTH = 1024;
   localparam logic [MAX_DATA_WIDTH-1:0] ZERO_WORD = '0;

   // Number of byte lanes in a word of width dw (dw must be a multiple of 8).
   function automatic int unsigned bytes_of(input int unsigned dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/sram_sdp_clr_if.sv
// Request/response bundle for sram_sdp_clr: clear pulse, write port, read port, status.
interface sram_sdp_clr_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                      i_clr;
   logic                      i_wr_en;
   logic [ADDR_WIDTH-1:0]     i_wr_addr;
   logic [DATA_WIDTH/8-1:0]   i_wr_be;
   logic [DATA_WIDTH-1:0]     i_wr_data;
   logic                      i_rd_en;
   logic [ADDR_WIDTH-1:0]     i_rd_addr;
   logic [DATA_WIDTH-1:0]     o_rd_data;
   logic                      o_rd_valid;
   logic                      o_ready;

   modport master (
      output i_clr, i_wr_en, i_wr_addr, i_wr_be, i_wr_data, i_rd_en, i_rd_addr,
      input  o_rd_data, o_rd_valid, o_ready
   );

   modport slave (
      input  i_clr, i_wr_en, i_wr_addr, i_wr_be, i_wr_data, i_rd_en, i_rd_addr,
      output o_rd_data, o_rd_valid, o_ready
   );
endinterface

// File: rtl/sram_clear_fsm.sv
// Clear sequencer: after reset or an i_clr pulse, walks ptr 0..DEPTH-1 issuing zero
// writes, then raises o_ready. All outputs are registered.
module sram_clear_fsm
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DEPTH      = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   output logic                  o_ready,
   output logic                  o_clr_we,
   output logic [ADDR_WIDTH-1:0] o_clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   ptr_q;
   logic                    ready_q;
   logic                    clr_we_q;

   // State, clear pointer and registered outputs advance together.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_CLEAR;
         ptr_q    <= '0;
         ready_q  <= 1'b0;
         clr_we_q <= 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (i_clr) begin
                  ptr_q <= '0;
               end else if (ptr_q == LAST_ADDR) begin
                  state_q  <= ST_RUN;
                  ptr_q    <= '0;
                  ready_q  <= 1'b1;
                  clr_we_q <= 1'b0;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (i_clr) begin
                  state_q  <= ST_CLEAR;
                  ptr_q    <= '0;
                  ready_q  <= 1'b0;
                  clr_we_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= ST_CLEAR;
               ptr_q    <= '0;
               ready_q  <= 1'b0;
               clr_we_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready    = ready_q;
   assign o_clr_we   = clr_we_q;
   assign o_clr_addr = ptr_q;

endmodule

// File: rtl/sram_sdp_clr.sv
// Simple-dual-port SRAM with byte-enable writes, registered read + valid, and a hardware
// zero-fill sequencer. Define SRAM_RD_BYPASS_EN for write-first same-address reads;
// otherwise a colliding read returns the old word.
module sram_sdp_clr
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   sram_sdp_clr_if.slave bus
);

   localparam int unsigned           BYTES   = bytes_of(DATA_WIDTH);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [DATA_WIDTH-1:0] ZERO    = ZERO_WORD[DATA_WIDTH-1:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  ready;
   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;

   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  wr_ok;
   logic                  rd_acc;
   logic                  bypass;
   logic [DATA_WIDTH-1:0] old_word;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;

   sram_clear_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_clear_fsm (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (bus.i_clr),
      .o_ready    (ready),
      .o_clr_we   (clr_we),
      .o_clr_addr (clr_addr)
   );

   assign wr_in_range = {1'b0, bus.i_wr_addr} < DEPTH_W;
   assign rd_in_range = {1'b0, bus.i_rd_addr} < DEPTH_W;
   // Reset cycle blocks requests even if o_ready is still high from a previous run.
   assign wr_ok       = ready & ~i_rst & bus.i_wr_en & wr_in_range;
   assign rd_acc      = ready & ~i_rst & bus.i_rd_en;

`ifdef SRAM_RD_BYPASS_EN
   assign bypass = wr_ok & (bus.i_wr_addr == bus.i_rd_addr);
`else
   assign bypass = 1'b0;
`endif

   // Byte merge of write data into the current word at the write address.
   always_comb begin
      old_word = wr_in_range ? mem[bus.i_wr_addr] : ZERO;
      merged   = old_word;
      for (int unsigned k = 0; k < BYTES; k++) begin
         if (bus.i_wr_be[k]) merged[8*k +: 8] = bus.i_wr_data[8*k +: 8];
      end
   end

   // Read word selection: out-of-range reads return zero; collision may bypass.
   always_comb begin
      rd_word = ZERO;
      if (rd_in_range) rd_word = mem[bus.i_rd_addr];
      if (bypass)      rd_word = merged;
   end

   // Array write port: clear sequencer and user writes never overlap (ready is low in clear).
   always_ff @(posedge i_clk) begin
      if (clr_we) begin
         mem[clr_addr] <= ZERO;
      end else if (wr_ok) begin
         mem[bus.i_wr_addr] <= merged;
      end
   end

   // Registered read data and valid; data holds when no read is accepted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_data_q  <= ZERO;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) rd_data_q <= rd_word;
      end
   end

   assign bus.o_rd_data  = rd_data_q;
   assign bus.o_rd_valid = rd_valid_q;
   assign bus.o_ready    = ready;

endmodule

// File: tb/tb_sram_sdp_clr.sv
// Directed bench for sram_sdp_clr with a read scoreboard; a DEPTH=20 instance covers
// out-of-range accesses.
module tb_sram_sdp_clr;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sram_sdp_clr_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();
   sram_sdp_clr_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus_s ();

   sram_sdp_clr #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(32)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   sram_sdp_clr #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(20)) u_small (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_s)
   );

   typedef struct {
      string       tag;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [32];
   logic [31:0] last_data;
   bit          rd_pend;
   int          n_assert;
   int          n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; checks the main port's read result (scoreboard) or idle/hold behaviour.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (rd_pend) begin
         e = sb.pop_front();
         chk({e.tag, "_valid"}, 32'(bus.o_rd_valid), 32'd1);
         chk(e.tag, bus.o_rd_data, e.data);
         last_data = e.data;
         rd_pend   = 1'b0;
      end else begin
         chk("idle_valid", 32'(bus.o_rd_valid), 32'd0);
         chk("hold_data", bus.o_rd_data, last_data);
      end
      bus.i_wr_en = 1'b0;
      bus.i_rd_en = 1'b0;
      bus.i_clr   = 1'b0;
      bus.i_wr_be = '0;
   endtask

   task automatic set_rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
      exp_t e;
      bus.i_rd_en   = 1'b1;
      bus.i_rd_addr = addr;
      e.tag  = tag;
      e.data = exp;
      sb.push_back(e);
      rd_pend = 1'b1;
   endtask

   task automatic set_wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be,
                         input bit upd);
      bus.i_wr_en   = 1'b1;
      bus.i_wr_addr = addr;
      bus.i_wr_data = data;
      bus.i_wr_be   = be;
      if (upd) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) model[addr][8*k +: 8] = data[8*k +: 8];
         end
      end
   endtask

   // Counts cycles with o_ready low (bounded); optionally pokes ignored requests at cycle 5.
   task automatic wait_ready(input string tag, input bit inject);
      int n = 0;
      while (!bus.o_ready && n < 100) begin
         n++;
         if (inject && n == 5) begin
            set_wr(5'd0, 32'hFFFF_FFFF, 4'hF, 1'b0);
            bus.i_rd_en   = 1'b1;
            bus.i_rd_addr = 5'd7;
         end
         step();
      end
      chk(tag, 32'(n), 32'd32);
      for (int a = 0; a < 32; a++) model[a] = '0;
   endtask

   task automatic do_reset(input string tag);
      rst       = 1'b1;
      rd_pend   = 1'b0;
      sb.delete();
      last_data = '0;
      step();
      chk("rst_ready", 32'(bus.o_ready), 32'd0);
      chk("rst_data", bus.o_rd_data, 32'd0);
      rst = 1'b0;
      wait_ready(tag, 1'b0);
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < 32; a++) begin
         set_rd(5'(a), model[a], tag);
         step();
      end
   endtask

   task automatic small_rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
      bus_s.i_rd_en   = 1'b1;
      bus_s.i_rd_addr = addr;
      step();
      bus_s.i_rd_en = 1'b0;
      chk({tag, "_valid"}, 32'(bus_s.o_rd_valid), 32'd1);
      chk(tag, bus_s.o_rd_data, exp);
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      rd_pend   = 1'b0;
      last_data = '0;
      bus.i_clr = 1'b0; bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_be = '0;
      bus.i_wr_data = '0; bus.i_rd_en = 1'b0; bus.i_rd_addr = '0;
      bus_s.i_clr = 1'b0; bus_s.i_wr_en = 1'b0; bus_s.i_wr_addr = '0; bus_s.i_wr_be = '0;
      bus_s.i_wr_data = '0; bus_s.i_rd_en = 1'b0; bus_s.i_rd_addr = '0;

      // Power-on clear: ready low exactly 32 cycles, then every word reads zero.
      do_reset("por_clear_len");
      chk("small_ready", 32'(bus_s.o_ready), 32'd1);
      read_all("por_zero");

      // Byte enables, including an all-zero enable no-op.
      set_wr(5'd3, 32'hDEAD_BEEF, 4'b1111, 1'b1); step();
      set_wr(5'd3, 32'h1122_3344, 4'b0101, 1'b1); step();
      set_rd(5'd3, 32'hDE22_BE44, "be_merge");    step();
      set_wr(5'd3, 32'hFFFF_FFFF, 4'b0000, 1'b1); step();
      set_rd(5'd3, 32'hDE22_BE44, "be_zero");     step();

      // Back-to-back reads, then valid drops and data holds.
      set_wr(5'd1, 32'd101,  4'hF, 1'b1); step();
      set_wr(5'd2, 32'd1004, 4'hF, 1'b1); step();
      set_wr(5'd3, 32'd15,   4'hF, 1'b1); step();
      set_rd(5'd1, 32'd101,  "pipe_1"); step();
      set_rd(5'd2, 32'd1004, "pipe_2"); step();
      set_rd(5'd3, 32'd15,   "pipe_3"); step();
      step();
      chk("pipe_hold", bus.o_rd_data, 32'd15);

      // Same-cycle read and write to different addresses.
      set_wr(5'd6, 32'h0BAD_CAFE, 4'hF, 1'b1);
      set_rd(5'd2, 32'd1004, "rw_diff_rd"); step();
      set_rd(5'd6, 32'h0BAD_CAFE, "rw_diff_wr"); step();

      // Same-address collision.
      set_wr(5'd5, 32'hAAAA_AAAA, 4'hF, 1'b1); step();
      set_wr(5'd5, 32'h5555_5555, 4'b0011, 1'b1);
`ifdef SRAM_RD_BYPASS_EN
      set_rd(5'd5, 32'hAAAA_5555, "collide");
`else
      set_rd(5'd5, 32'hAAAA_AAAA, "collide");
`endif
      step();
      set_rd(5'd5, 32'hAAAA_5555, "collide_after"); step();

      // Out-of-range on the DEPTH=20 instance.
      bus_s.i_wr_en = 1'b1; bus_s.i_wr_be = 4'hF;
      bus_s.i_wr_addr = 5'd19; bus_s.i_wr_data = 32'hCAFE_F00D; step();
      bus_s.i_wr_addr = 5'd25; bus_s.i_wr_data = 32'h1234_5678; step();
      bus_s.i_wr_en = 1'b0;
      small_rd(5'd19, 32'hCAFE_F00D, "small_last");
      small_rd(5'd25, 32'd0, "small_oor_wr");
      small_rd(5'd31, 32'd0, "small_oor_31");

      // Clear mid-run; requests during clear are ignored.
      for (int a = 0; a < 8; a++) begin
         set_wr(5'(a), 32'h1000_0000 + 32'(a * 3 + 1), 4'hF, 1'b1);
         step();
      end
      set_rd(5'd7, model[7], "pre_clr"); step();
      bus.i_clr = 1'b1;
      step();
      chk("clr_ready_drop", 32'(bus.o_ready), 32'd0);
      wait_ready("clr_len", 1'b1);
      read_all("clr_zero");

      // Reset at clear cycle 10 restarts the full 32-cycle clear.
      set_wr(5'd9, 32'h0000_00F0, 4'hF, 1'b1); step();
      bus.i_clr = 1'b1;
      step();
      for (int i = 0; i < 10; i++) step();
      do_reset("rst_mid_clear_len");
      set_rd(5'd9, 32'd0, "rst_zero_9"); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
